sprite_table: RTL and testbench

Parametrised successor of the single-type enemy store: a fixed-depth table of on-screen sprites (position + live flag) that is rebuilt once per frame during the `calc` window and, outside it, resolves the current beam pixel to the lowest-index sprite covering it. Each frame update runs four steps: compact live entries, accept at most one spawn, apply a per-frame row step, and cull sprites that leave the playfield. It sits between the game controller (spawn/step source) and the pixel mixer (consumer of `hit_*`). The mixer uses `hit_u`/`hit_v` to address the sprite image ROM.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_hit_match.sv | 30 +++
 rtl/sprite_table.sv | 235 +++++++++++++++++++++++
 tb/tb_sprite_table.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite table and its per-slot comparator.
package sprite_pkg;

    localparam int DEF_SLOTS     = 64;
    localparam int DEF_COL_W     = 12;
    localparam int DEF_ROW_W     = 11;
    localparam int DEF_SIZE_LOG2 = 6;
    localparam int DEF_ROW_LIMIT = 1080;
    localparam int DEF_SIZE      = 1 << DEF_SIZE_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPACT,
        ST_SPAWN,
        ST_MOVE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sprite_hit_match.sv
// Per-slot range compare: does the beam pixel fall inside this sprite's square?
module sprite_hit_match #(
    parameter int COL_W     = 12,
    parameter int ROW_W     = 11,
    parameter int SIZE_LOG2 = 6
) (
    input  logic                 live,
    input  logic [COL_W-1:0]     col,
    input  logic [ROW_W-1:0]     row,
    input  logic [COL_W-1:0]     display_col,
    input  logic [ROW_W-1:0]     display_row,
    output logic                 match,
    output logic [SIZE_LOG2-1:0] u,
    output logic [SIZE_LOG2-1:0] v
);

    logic [COL_W:0] dcol;
    logic [ROW_W:0] drow;

    // One extra bit keeps a beam left of / above the sprite from wrapping into range.
    assign dcol = {1'b0, display_col} - {1'b0, col};
    assign drow = {1'b0, display_row} - {1'b0, row};

    assign match = live
                && (dcol[COL_W:SIZE_LOG2] == '0)
                && (drow[ROW_W:SIZE_LOG2] == '0);
    assign u = dcol[SIZE_LOG2-1:0];
    assign v = drow[SIZE_LOG2-1:0];

endmodule

// File: rtl/sprite_table.sv
// Per-frame sprite table: compact / spawn / move / cull during calc, beam hit lookup otherwise.
module sprite_table
    import sprite_pkg::*;
#(
    parameter int SLOTS     = DEF_SLOTS,
    parameter int COL_W     = DEF_COL_W,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int SIZE_LOG2 = DEF_SIZE_LOG2,
    parameter int ROW_LIMIT = DEF_ROW_LIMIT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       calc,
    input  logic [COL_W-1:0]           display_col,
    input  logic [ROW_W-1:0]           display_row,
    input  logic                       spawn_valid,
    input  logic [COL_W-1:0]           spawn_col,
    input  logic [ROW_W-1:0]           spawn_row,
    output logic                       spawn_ready,
    input  logic [7:0]                 move_dy,
    output logic                       hit,
    output logic [$clog2(SLOTS)-1:0]   hit_slot,
    output logic [SIZE_LOG2-1:0]       hit_u,
    output logic [SIZE_LOG2-1:0]       hit_v,
    output logic [$clog2(SLOTS):0]     live_count,
    output logic                       busy
);

    localparam int IDX_W = $clog2(SLOTS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(SLOTS);
    localparam logic [ROW_W:0]   LIMIT     = (ROW_W + 1)'(ROW_LIMIT);

    typedef struct packed {
        logic             live;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } entry_t;

    entry_t             slot_reg [SLOTS];
    state_t             state_reg, state_next;
    logic               calc_reg;
    logic [IDX_W-1:0]   rptr_reg, rptr_next;
    logic [CNT_W-1:0]   wptr_reg, wptr_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_spawn;
    logic               spawn_ok;

    logic                 hit_reg;
    logic [IDX_W-1:0]     hit_slot_reg;
    logic [SIZE_LOG2-1:0] hit_u_reg, hit_v_reg;

    entry_t         cur;
    logic [ROW_W:0] dy_ext;
    logic [ROW_W:0] new_row;
    logic           cull;

    assign cur     = slot_reg[rptr_reg];
    assign dy_ext  = {{(ROW_W - 7){move_dy[7]}}, move_dy};
    assign new_row = {1'b0, cur.row} + dy_ext;
    // Sign bit set means the sprite moved above row 0.
    assign cull    = new_row[ROW_W] || (new_row >= LIMIT);

    always_comb begin
        state_next  = state_reg;
        rptr_next   = rptr_reg;
        wptr_next   = wptr_reg;
        spawn_ok    = 1'b0;
        count_spawn = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (calc && !calc_reg) begin
                    state_next = ST_COMPACT;
                    rptr_next  = '0;
                    wptr_next  = '0;
                end
            end
            ST_COMPACT: begin
                if (cur.live) begin
                    wptr_next = wptr_reg + CNT_W'(1);
                end
                rptr_next = rptr_reg + IDX_W'(1);
                if (rptr_reg == LAST_SLOT) begin
                    state_next = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                spawn_ok    = spawn_valid && (count_reg != FULL);
                count_spawn = count_reg + CNT_W'(spawn_ok);
                rptr_next   = '0;
                state_next  = (count_spawn == '0) ? ST_DONE : ST_MOVE;
            end
            ST_MOVE: begin
                rptr_next = rptr_reg + IDX_W'(1);
                if (({1'b0, rptr_reg} + CNT_W'(1)) == count_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!calc) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic [SLOTS-1:0]     match;
    logic [SIZE_LOG2-1:0] u_arr [SLOTS];
    logic [SIZE_LOG2-1:0] v_arr [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic   we;
            entry_t wdata;

            always_comb begin
                we    = 1'b0;
                wdata = slot_reg[gi];
                case (state_reg)
                    ST_COMPACT: begin
                        if (cur.live && (wptr_reg == CNT_W'(gi))) begin
                            we    = 1'b1;
                            wdata = cur;
                        end else if ((rptr_reg == IDX_W'(gi)) && ({1'b0, rptr_reg} != wptr_reg)) begin
                            we         = 1'b1;
                            wdata.live = 1'b0;
                        end
                    end
                    ST_SPAWN: begin
                        if (spawn_ok && (count_reg == CNT_W'(gi))) begin
                            we    = 1'b1;
                            wdata = '{live: 1'b1, col: spawn_col, row: spawn_row};
                        end
                    end
                    ST_MOVE: begin
                        if (cur.live && (rptr_reg == IDX_W'(gi))) begin
                            we = 1'b1;
                            if (cull) begin
                                wdata.live = 1'b0;
                            end else begin
                                wdata.row = new_row[ROW_W-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    slot_reg[gi] <= '0;
                end else if (we) begin
                    slot_reg[gi] <= wdata;
                end
            end

            sprite_hit_match #(
                .COL_W     (COL_W),
                .ROW_W     (ROW_W),
                .SIZE_LOG2 (SIZE_LOG2)
            ) u_match (
                .live        (slot_reg[gi].live),
                .col         (slot_reg[gi].col),
                .row         (slot_reg[gi].row),
                .display_col (display_col),
                .display_row (display_row),
                .match       (match[gi]),
                .u           (u_arr[gi]),
                .v           (v_arr[gi])
            );
        end
    endgenerate

    logic                 found;
    logic [IDX_W-1:0]     sel;
    logic [SIZE_LOG2-1:0] sel_u, sel_v;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        sel_u = '0;
        sel_v = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && match[i]) begin
                found = 1'b1;
                sel   = IDX_W'(i);
                sel_u = u_arr[i];
                sel_v = v_arr[i];
            end
        end
    end

    // Blank the lookup on the edge that leaves IDLE so no stale hit shows during an update.
    logic display_en;
    assign display_en = (state_reg == ST_IDLE) && (state_next == ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            calc_reg     <= 1'b0;
            rptr_reg     <= '0;
            wptr_reg     <= '0;
            count_reg    <= '0;
            hit_reg      <= 1'b0;
            hit_slot_reg <= '0;
            hit_u_reg    <= '0;
            hit_v_reg    <= '0;
        end else begin
            state_reg <= state_next;
            calc_reg  <= calc;
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            if ((state_reg == ST_COMPACT) && (rptr_reg == LAST_SLOT)) begin
                count_reg <= wptr_next;
            end else if (spawn_ok) begin
                count_reg <= count_spawn;
            end
            hit_reg      <= display_en && found;
            hit_slot_reg <= display_en ? sel   : '0;
            hit_u_reg    <= display_en ? sel_u : '0;
            hit_v_reg    <= display_en ? sel_v : '0;
        end
    end

    assign spawn_ready = spawn_ok;
    assign hit         = hit_reg;
    assign hit_slot    = hit_slot_reg;
    assign hit_u       = hit_u_reg;
    assign hit_v       = hit_v_reg;
    assign live_count  = count_reg;
    assign busy        = (state_reg == ST_COMPACT) || (state_reg == ST_SPAWN) || (state_reg == ST_MOVE);

endmodule

// File: tb/tb_sprite_table.sv
// Scoreboard bench for sprite_table: stimulus queues expected pixel/frame results, a monitor checks them.
module tb_sprite_table;

    localparam int SLOTS     = 8;
    localparam int COL_W     = 12;
    localparam int ROW_W     = 11;
    localparam int SIZE_LOG2 = 6;
    localparam int ROW_LIMIT = 1080;

    logic                 clock;
    logic                 reset;
    logic                 calc;
    logic [COL_W-1:0]     display_col;
    logic [ROW_W-1:0]     display_row;
    logic                 spawn_valid;
    logic [COL_W-1:0]     spawn_col;
    logic [ROW_W-1:0]     spawn_row;
    logic                 spawn_ready;
    logic [7:0]           move_dy;
    logic                 hit;
    logic [2:0]           hit_slot;
    logic [SIZE_LOG2-1:0] hit_u;
    logic [SIZE_LOG2-1:0] hit_v;
    logic [3:0]           live_count;
    logic                 busy;

    sprite_table #(
        .SLOTS     (SLOTS),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W),
        .SIZE_LOG2 (SIZE_LOG2),
        .ROW_LIMIT (ROW_LIMIT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .calc        (calc),
        .display_col (display_col),
        .display_row (display_row),
        .spawn_valid (spawn_valid),
        .spawn_col   (spawn_col),
        .spawn_row   (spawn_row),
        .spawn_ready (spawn_ready),
        .move_dy     (move_dy),
        .hit         (hit),
        .hit_slot    (hit_slot),
        .hit_u       (hit_u),
        .hit_v       (hit_v),
        .live_count  (live_count),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int    hit;
        int    slot;
        int    u;
        int    v;
        string name;
    } pix_t;

    typedef struct {
        int    acc;
        int    cnt;
        int    len;
        string name;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];

    int   checks = 0;
    int   errors = 0;
    logic probe_req = 1'b0;
    logic probe_d;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clock) probe_d <= probe_req;

    // Monitor: pixel results one cycle after a probe, frame results when busy drops.
    initial begin
        int   busy_cycles;
        int   ready_cnt;
        logic busy_prev;
        pix_t p;
        frm_t f;
        busy_cycles = 0;
        ready_cnt   = 0;
        busy_prev   = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                busy_cycles = 0;
                ready_cnt   = 0;
                busy_prev   = 1'b0;
            end else begin
                if (probe_d) begin
                    if (pix_q.size() == 0) begin
                        errors++;
                        $display("FAIL pixel_unexpected: got a probe result, expected none queued");
                    end else begin
                        p = pix_q.pop_front();
                        $display("pix  %-22s hit=%0d slot=%0d u=%0d v=%0d", p.name, hit, hit_slot, hit_u, hit_v);
                        check({p.name, " hit"},  int'(hit),      p.hit);
                        check({p.name, " slot"}, int'(hit_slot), p.slot);
                        check({p.name, " u"},    int'(hit_u),    p.u);
                        check({p.name, " v"},    int'(hit_v),    p.v);
                    end
                end
                if (spawn_ready) ready_cnt++;
                if (busy) busy_cycles++;
                if (busy_prev && !busy) begin
                    if (frm_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got an update end, expected none queued");
                    end else begin
                        f = frm_q.pop_front();
                        $display("frm  %-22s accepted=%0d live_count=%0d cycles=%0d", f.name, ready_cnt, live_count, busy_cycles);
                        check({f.name, " spawn_ready"}, ready_cnt,        f.acc);
                        check({f.name, " live_count"},  int'(live_count), f.cnt);
                        check({f.name, " length"},      busy_cycles,      f.len);
                    end
                    busy_cycles = 0;
                    ready_cnt   = 0;
                end
                busy_prev = busy;
            end
        end
    end

    task automatic do_reset(input string name);
        @(negedge clock);
        reset       = 1'b0;
        calc        = 1'b0;
        spawn_valid = 1'b0;
        repeat (2) @(negedge clock);
        $display("rst  %-22s hit=%0d live_count=%0d busy=%0d", name, hit, live_count, busy);
        check({name, " hit"},         int'(hit),         0);
        check({name, " hit_slot"},    int'(hit_slot),    0);
        check({name, " live_count"},  int'(live_count),  0);
        check({name, " busy"},        int'(busy),        0);
        check({name, " spawn_ready"}, int'(spawn_ready), 0);
        reset = 1'b1;
    endtask

    task automatic probe(input string name, input int col, input int row,
                         input int eh, input int es, input int eu, input int ev);
        @(negedge clock);
        display_col = col[COL_W-1:0];
        display_row = row[ROW_W-1:0];
        pix_q.push_back('{eh, es, eu, ev, name});
        probe_req = 1'b1;
        @(negedge clock);
        probe_req = 1'b0;
    endtask

    // Expected update length is SLOTS + 1 + live_count after the spawn step.
    task automatic frame(input string name, input bit sv, input int sc, input int sr, input int dy,
                         input int exp_acc, input int exp_cnt, input bit short_calc);
        int n;
        bit seen;
        bit done;
        @(negedge clock);
        spawn_valid = sv;
        spawn_col   = sc[COL_W-1:0];
        spawn_row   = sr[ROW_W-1:0];
        move_dy     = dy[7:0];
        calc        = 1'b1;
        frm_q.push_back('{exp_acc, exp_cnt, SLOTS + 1 + exp_cnt, name});
        n    = 0;
        seen = 1'b0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
            if (short_calc && n == 3) calc = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no update end within %0d cycles, expected one", name, n);
        end
        calc        = 1'b0;
        spawn_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        reset       = 1'b0;
        calc        = 1'b0;
        display_col = '0;
        display_row = '0;
        spawn_valid = 1'b0;
        spawn_col   = '0;
        spawn_row   = '0;
        move_dy     = '0;

        // Basic spawn and sprite edges.
        do_reset("reset A");
        frame("A0 empty", 0, 0, 0, 0, 0, 0, 0);
        frame("A1 spawn", 1, 100, 200, 0, 1, 1, 0);
        probe("A far corner",   163, 263, 1, 0, 63, 63);
        probe("A right of",     164, 263, 0, 0, 0, 0);
        probe("A left of",       99, 263, 0, 0, 0, 0);
        probe("A origin",       100, 200, 1, 0, 0, 0);
        probe("A below",        163, 264, 0, 0, 0, 0);
        probe("A above",        120, 199, 0, 0, 0, 0);

        // Negative cull and order-preserving compaction.
        do_reset("reset B");
        frame("B1 spawn", 1,  10, 500,    0, 1, 1, 0);
        frame("B2 spawn", 1, 300,  20,    0, 1, 2, 0);
        frame("B3 spawn up", 1, 600, 700, -100, 1, 3, 0);
        probe("B culled slot1",  300,  20, 0, 0, 0, 0);
        probe("B slot0 moved",    10, 400, 1, 0, 0, 0);
        probe("B slot0 old row",  10, 500, 0, 0, 0, 0);
        probe("B slot2",         605, 607, 1, 2, 5, 7);
        frame("B4 compact", 0, 0, 0, 0, 0, 2, 0);
        probe("B slot2 to 1",    605, 607, 1, 1, 5, 7);
        probe("B slot0 kept",     10, 400, 1, 0, 0, 0);

        // Overlap priority and a full table.
        do_reset("reset C");
        frame("C0 spawn", 1, 50, 50, 0, 1, 1, 0);
        frame("C1 spawn", 1, 50, 50, 0, 1, 2, 0);
        probe("C overlap",        80,  90, 1, 0, 30, 40);
        for (int k = 2; k < SLOTS; k++) begin
            frame("C fill", 1, 1000, 50, 0, 1, k + 1, 0);
        end
        probe("C overlap full",   50,  50, 1, 0, 0, 0);
        probe("C slot2 wins",   1000,  50, 1, 2, 0, 0);
        frame("C full",       1, 300, 300, 0, 0, SLOTS, 0);
        frame("C full again", 1, 300, 300, 0, 0, SLOTS, 1);
        probe("C no spawn",      300, 300, 0, 0, 0, 0);

        // Playfield limit.
        do_reset("reset D");
        frame("D1 spawn", 1, 400, ROW_LIMIT - 9, 8, 1, 1, 0);
        probe("D last row",      400, ROW_LIMIT - 1, 1, 0, 0, 0);
        frame("D2 spawn", 1, 700, ROW_LIMIT - 4, 8, 1, 2, 0);
        probe("D slot0 culled",  400, ROW_LIMIT + 7, 0, 0, 0, 0);
        probe("D slot1 culled",  700, ROW_LIMIT + 4, 0, 0, 0, 0);
        probe("D slot1 origin",  700, ROW_LIMIT - 4, 0, 0, 0, 0);
        frame("D3 short calc", 0, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of COMPACT.
        do_reset("reset E");
        frame("E1 spawn", 1, 5, 5, 0, 1, 1, 0);
        probe("E present", 5, 5, 1, 0, 0, 0);
        @(negedge clock);
        calc = 1'b1;
        repeat (4) @(negedge clock);
        check("E mid busy", int'(busy), 1);
        do_reset("reset mid compact");
        probe("E after abort", 5, 5, 0, 0, 0, 0);
        frame("E2 empty", 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        check("pixel queue drained", pix_q.size(), 0);
        check("frame queue drained", frm_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
